// File: rtl/mioc_dma_req.sv
// ---------------------------------------------------------------------------
// mioc_dma_req -- DMA block-transfer requester for the MIOC RAM bus.
//
// On START (sampled only while idle) it latches direction, base address and
// byte count. It then requests the bus from the MIOC (OS3_N) and waits for the
// grant (IS3_N), giving up after TIMEOUT cycles. For each byte it runs a fixed
// SETUP / STROBE / NEXT sequence, with STROBE stretched by WAIT_N. Finally it
// releases the bus and waits for the MIOC to drop the grant. If the grant
// disappears mid-transfer, the block aborts.
//
// Ports
//   B_PHI      in   system clock, rising edge
//   RESET      in   asynchronous active-high reset
//   START      in   begin a block transfer (idle only)
//   WR         in   1 = write RAM (N_BWR), 0 = read RAM (BRD_N)
//   BASE_ADDR  in   [15:0] first transfer address
//   COUNT      in   [7:0] byte count, 0 encodes 256
//   IS3_N      in   bus grant from MIOC, active low
//   WAIT_N     in   memory wait, active low
//   OS3_N      out  bus request to MIOC, active low
//   DMA_N      out  low while this block owns the RAM bus
//   BA         out  [15:0] current transfer address
//   N_BWR      out  write strobe, active low
//   BRD_N      out  read strobe, active low
//   BUSY       out  high whenever not idle
//   DONE       out  one-cycle pulse on normal completion
//   ERR        out  one-cycle pulse on grant timeout or grant loss
// ---------------------------------------------------------------------------
module mioc_dma_req #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        B_PHI,
   input  logic        RESET,
   input  logic        START,
   input  logic        WR,
   input  logic [15:0] BASE_ADDR,
   input  logic [7:0]  COUNT,
   input  logic        IS3_N,
   input  logic        WAIT_N,
   output logic        OS3_N,
   output logic        DMA_N,
   output logic [15:0] BA,
   output logic        N_BWR,
   output logic        BRD_N,
   output logic        BUSY,
   output logic        DONE,
   output logic        ERR
);

   // Wait counter only needs to reach TIMEOUT-1: the grant check on the edge
   // where it holds TIMEOUT-1 is the TIMEOUT-th edge spent in REQ.
   localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
   localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_REQ     = 3'd1,
      S_SETUP   = 3'd2,
      S_STROBE  = 3'd3,
      S_NEXT    = 3'd4,
      S_RELEASE = 3'd5
   } state_t;

   state_t          r_state;
   logic            r_wr;
   logic [15:0]     r_addr;
   logic [7:0]      r_remain;   // bytes left after the current one
   logic [CW-1:0]   r_wait;

   logic            r_os3_n;
   logic            r_dma_n;
   logic [15:0]     r_ba;
   logic            r_n_bwr;
   logic            r_brd_n;
   logic            r_busy;
   logic            r_done;
   logic            r_err;

   state_t          w_state_nxt;
   logic            w_latch;
   logic            w_advance;
   logic            w_done_nxt;
   logic            w_err_nxt;
   logic [15:0]     w_addr_nxt;
   logic [7:0]      w_remain_nxt;
   logic [CW-1:0]   w_wait_nxt;
   logic            w_os3_n_nxt;
   logic            w_dma_n_nxt;
   logic [15:0]     w_ba_nxt;
   logic            w_n_bwr_nxt;
   logic            w_brd_n_nxt;

   // Next-state selection and completion/error pulse generation.
   always_comb begin
      w_state_nxt = r_state;
      w_latch     = 1'b0;
      w_advance   = 1'b0;
      w_done_nxt  = 1'b0;
      w_err_nxt   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (START) begin
               w_state_nxt = S_REQ;
               w_latch     = 1'b1;
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         S_REQ: begin
            if (!IS3_N) begin
               w_state_nxt = S_SETUP;
            end else if (r_wait == WAIT_LAST) begin
               w_state_nxt = S_IDLE;
               w_err_nxt   = 1'b1;
            end else begin
               w_state_nxt = S_REQ;
            end
         end
         S_SETUP: begin
            if (IS3_N) begin
               w_state_nxt = S_IDLE;
               w_err_nxt   = 1'b1;
            end else begin
               w_state_nxt = S_STROBE;
            end
         end
         S_STROBE: begin
            // Grant loss takes priority over a memory wait.
            if (IS3_N) begin
               w_state_nxt = S_IDLE;
               w_err_nxt   = 1'b1;
            end else if (!WAIT_N) begin
               w_state_nxt = S_STROBE;
            end else begin
               w_state_nxt = S_NEXT;
            end
         end
         S_NEXT: begin
            if (IS3_N) begin
               w_state_nxt = S_IDLE;
               w_err_nxt   = 1'b1;
            end else begin
               w_advance = 1'b1;
               if (r_remain == 8'd0) begin
                  w_state_nxt = S_RELEASE;
               end else begin
                  w_state_nxt = S_SETUP;
               end
            end
         end
         S_RELEASE: begin
            if (IS3_N) begin
               w_state_nxt = S_IDLE;
               w_done_nxt  = 1'b1;
            end else begin
               w_state_nxt = S_RELEASE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // Datapath next values: latched parameters, address/count stepping, wait counter.
   always_comb begin
      w_addr_nxt   = r_addr;
      w_remain_nxt = r_remain;
      if (w_latch) begin
         w_addr_nxt   = BASE_ADDR;
         w_remain_nxt = COUNT - 8'd1;   // COUNT=0 gives 255 more, i.e. 256 bytes
      end else if (w_advance) begin
         w_addr_nxt   = r_addr + 16'd1;
         w_remain_nxt = r_remain - 8'd1;
      end else begin
         w_addr_nxt   = r_addr;
         w_remain_nxt = r_remain;
      end
      if (r_state == S_REQ) begin
         w_wait_nxt = r_wait + CW'(1);
      end else begin
         w_wait_nxt = '0;
      end
   end

   // Output values decoded from the state being entered, so they can be registered.
   always_comb begin
      w_os3_n_nxt = 1'b1;
      w_dma_n_nxt = 1'b1;
      w_n_bwr_nxt = 1'b1;
      w_brd_n_nxt = 1'b1;
      w_ba_nxt    = r_ba;
      case (w_state_nxt)
         S_REQ: begin
            w_os3_n_nxt = 1'b0;
         end
         S_SETUP: begin
            w_os3_n_nxt = 1'b0;
            w_dma_n_nxt = 1'b0;
            w_ba_nxt    = w_addr_nxt;
         end
         S_STROBE: begin
            w_os3_n_nxt = 1'b0;
            w_dma_n_nxt = 1'b0;
            if (r_wr) begin
               w_n_bwr_nxt = 1'b0;
            end else begin
               w_brd_n_nxt = 1'b0;
            end
         end
         S_NEXT: begin
            w_os3_n_nxt = 1'b0;
            w_dma_n_nxt = 1'b0;
         end
         default: begin
            w_os3_n_nxt = 1'b1;
            w_dma_n_nxt = 1'b1;
         end
      endcase
   end

   // State, datapath and registered outputs.
   always_ff @(posedge B_PHI or posedge RESET) begin
      if (RESET) begin
         r_state  <= S_IDLE;
         r_wr     <= 1'b0;
         r_addr   <= 16'h0000;
         r_remain <= 8'd0;
         r_wait   <= '0;
         r_os3_n  <= 1'b1;
         r_dma_n  <= 1'b1;
         r_ba     <= 16'h0000;
         r_n_bwr  <= 1'b1;
         r_brd_n  <= 1'b1;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_err    <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         if (w_latch) begin
            r_wr <= WR;
         end else begin
            r_wr <= r_wr;
         end
         r_addr   <= w_addr_nxt;
         r_remain <= w_remain_nxt;
         r_wait   <= w_wait_nxt;
         r_os3_n  <= w_os3_n_nxt;
         r_dma_n  <= w_dma_n_nxt;
         r_ba     <= w_ba_nxt;
         r_n_bwr  <= w_n_bwr_nxt;
         r_brd_n  <= w_brd_n_nxt;
         r_busy   <= (w_state_nxt != S_IDLE);
         r_done   <= w_done_nxt;
         r_err    <= w_err_nxt;
      end
   end

   assign OS3_N = r_os3_n;
   assign DMA_N = r_dma_n;
   assign BA    = r_ba;
   assign N_BWR = r_n_bwr;
   assign BRD_N = r_brd_n;
   assign BUSY  = r_busy;
   assign DONE  = r_done;
   assign ERR   = r_err;

endmodule

// File: tb/tb_mioc_dma_req.sv
// ---------------------------------------------------------------------------
// tb_mioc_dma_req -- self-checking bench for mioc_dma_req.
// The driver walks each block transfer as a sequence of bus phases and, for
// every clock, states what the outputs must be afterwards; one compare
// process checks those expectations every cycle. A monitor records strobe
// starts, strobe-low cycles and pulse times for hand-computed literal checks.
// ---------------------------------------------------------------------------
module tb_mioc_dma_req;

   localparam int TO = 255;

   logic        B_PHI = 1'b0;
   logic        RESET;
   logic        START;
   logic        WR;
   logic [15:0] BASE_ADDR;
   logic [7:0]  COUNT;
   logic        IS3_N;
   logic        WAIT_N;
   logic        OS3_N;
   logic        DMA_N;
   logic [15:0] BA;
   logic        N_BWR;
   logic        BRD_N;
   logic        BUSY;
   logic        DONE;
   logic        ERR;

   mioc_dma_req #(.TIMEOUT(TO)) dut (
      .B_PHI(B_PHI), .RESET(RESET), .START(START), .WR(WR),
      .BASE_ADDR(BASE_ADDR), .COUNT(COUNT), .IS3_N(IS3_N), .WAIT_N(WAIT_N),
      .OS3_N(OS3_N), .DMA_N(DMA_N), .BA(BA), .N_BWR(N_BWR), .BRD_N(BRD_N),
      .BUSY(BUSY), .DONE(DONE), .ERR(ERR)
   );

   always #5 B_PHI = ~B_PHI;

   // expected outputs for the cycle following the next rising edge
   logic        e_os3_n, e_dma_n, e_n_bwr, e_brd_n, e_busy, e_done, e_err;
   logic [15:0] e_ba;
   logic        e_ba_chk;
   logic        chk_en = 1'b0;
   logic        force_start = 1'b0;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;

   // monitor records
   int          st_cyc[$];
   logic [15:0] st_ba[$];
   int          strobe_low_cycles = 0;
   logic        prev_strobe_low = 1'b0;
   logic        prev_os3_n = 1'b1;
   int          os3_fall_cyc = 0;
   int          err_cyc = 0;
   int          err_cnt = 0;
   int          done_cnt = 0;

   // Per-cycle comparison against the expectation, plus event monitor.
   always @(posedge B_PHI) begin
      logic [6:0] act_v;
      logic [6:0] exp_v;
      logic       strobe_low;
      #1;
      cyc++;
      act_v = {OS3_N, DMA_N, N_BWR, BRD_N, BUSY, DONE, ERR};
      exp_v = {e_os3_n, e_dma_n, e_n_bwr, e_brd_n, e_busy, e_done, e_err};
      if (chk_en) begin
         n_checks++;
         if (act_v != exp_v || (e_ba_chk && BA != e_ba)) begin
            n_errors++;
            $display("FAIL cycle_cmp @%0d: got os3,dma,bwr,brd,busy,done,err=%b BA=%h; expected %b BA=%h (ba checked=%0d)",
                     cyc, act_v, BA, exp_v, e_ba, e_ba_chk);
         end
      end
      if (!RESET) begin
         strobe_low = !N_BWR || !BRD_N;
         if (strobe_low && !prev_strobe_low) begin
            st_cyc.push_back(cyc);
            st_ba.push_back(BA);
         end
         if (strobe_low) strobe_low_cycles++;
         if (!OS3_N && prev_os3_n) os3_fall_cyc = cyc;
         if (ERR) begin err_cyc = cyc; err_cnt++; end
         if (DONE) done_cnt++;
         prev_strobe_low = strobe_low;
         prev_os3_n = OS3_N;
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   task automatic step(input logic os3_n, input logic dma_n, input logic [15:0] ba,
                       input logic ba_chk, input logic n_bwr, input logic brd_n,
                       input logic busy, input logic done, input logic err);
      e_os3_n = os3_n; e_dma_n = dma_n; e_ba = ba; e_ba_chk = ba_chk;
      e_n_bwr = n_bwr; e_brd_n = brd_n; e_busy = busy; e_done = done; e_err = err;
      @(negedge B_PHI);
   endtask

   task automatic exp_idle(input logic done, input logic err);
      step(1'b1, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, done, err);
   endtask
   task automatic exp_req();
      step(1'b0, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
   endtask
   task automatic exp_setup(input logic [15:0] a);
      step(1'b0, 1'b0, a, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
   endtask
   task automatic exp_strobe(input logic wr, input logic [15:0] a);
      step(1'b0, 1'b0, a, 1'b1, !wr, wr, 1'b1, 1'b0, 1'b0);
   endtask
   task automatic exp_rel();
      step(1'b1, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
   endtask

   // inputs that must not matter in the current phase
   task automatic junk();
      START     = force_start ? 1'b1 : 1'($urandom);
      WR        = 1'($urandom);
      BASE_ADDR = 16'($urandom);
      COUNT     = 8'($urandom);
      WAIT_N    = 1'($urandom);
   endtask

   // One block transfer from IDLE back to IDLE. fixed_w<0 means random waits.
   task automatic xfer(input logic wr, input logic [15:0] base, input logic [7:0] cnt,
                       input int gdly, input int fixed_w, input int maxw, input int abort_byte);
      int          nbytes;
      int          w;
      int          rd;
      logic [15:0] a;
      logic        aborted;
      nbytes  = (cnt == 8'd0) ? 256 : int'(cnt);
      aborted = 1'b0;
      START = 1'b1; WR = wr; BASE_ADDR = base; COUNT = cnt; IS3_N = 1'b1; WAIT_N = 1'($urandom);
      exp_req();
      for (int i = 0; i < gdly; i++) begin
         junk(); IS3_N = 1'b1; exp_req();
      end
      junk(); IS3_N = 1'b0; exp_setup(base);
      for (int b = 0; b < nbytes && !aborted; b++) begin
         a = base + 16'(b);
         w = (fixed_w >= 0) ? fixed_w : int'($urandom_range(0, maxw));
         junk(); IS3_N = 1'b0; exp_strobe(wr, a);
         if (b == abort_byte) begin
            junk(); IS3_N = 1'b1; exp_idle(1'b0, 1'b1);
            aborted = 1'b1;
         end else begin
            for (int k = 0; k < w; k++) begin
               junk(); IS3_N = 1'b0; WAIT_N = 1'b0; exp_strobe(wr, a);
            end
            junk(); IS3_N = 1'b0; WAIT_N = 1'b1; exp_setup(a);   // NEXT: same outputs as SETUP
            junk(); IS3_N = 1'b0;
            if (b == nbytes - 1) exp_rel(); else exp_setup(a + 16'd1);
         end
      end
      if (!aborted) begin
         rd = int'($urandom_range(0, 3));
         for (int i = 0; i < rd; i++) begin
            junk(); IS3_N = 1'b0; exp_rel();
         end
         junk(); IS3_N = 1'b1; exp_idle(1'b1, 1'b0);
      end
      START = 1'b0; IS3_N = 1'b1; exp_idle(1'b0, 1'b0);
   endtask

   task automatic clear_mon();
      st_cyc.delete();
      st_ba.delete();
      strobe_low_cycles = 0;
      done_cnt = 0;
      err_cnt = 0;
   endtask

   initial begin
      RESET = 1'b1; START = 1'b0; WR = 1'b0; BASE_ADDR = 16'h0; COUNT = 8'd0;
      IS3_N = 1'b1; WAIT_N = 1'b1;
      #1;
      chk("reset_outputs_initial", int'({OS3_N, DMA_N, N_BWR, BRD_N, BUSY, DONE, ERR, BA}), 32'h0078_0000);
      repeat (3) @(negedge B_PHI);
      RESET = 1'b0;
      chk_en = 1'b1;
      step(1'b1, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      exp_idle(1'b0, 1'b0);

      // write block: 3 bytes at 6000, no waits
      clear_mon();
      xfer(1'b1, 16'h6000, 8'd3, 2, 0, 0, -1);
      chk("wr_strobe_count", st_ba.size(), 3);
      if (st_ba.size() == 3) begin
         chk("wr_ba0", int'(st_ba[0]), 32'h6000);
         chk("wr_ba1", int'(st_ba[1]), 32'h6001);
         chk("wr_ba2", int'(st_ba[2]), 32'h6002);
         chk("wr_spacing01", st_cyc[1] - st_cyc[0], 3);
         chk("wr_spacing12", st_cyc[2] - st_cyc[1], 3);
      end
      chk("wr_done_count", done_cnt, 1);

      // read block with 4 waits: strobe low 5 cycles
      clear_mon();
      xfer(1'b0, 16'h1F00, 8'd1, 1, 4, 0, -1);
      chk("rd_strobe_low_cycles", strobe_low_cycles, 5);
      chk("rd_done_count", done_cnt, 1);

      // grant timeout
      clear_mon();
      START = 1'b1; WR = 1'b1; BASE_ADDR = 16'h0100; COUNT = 8'd2; IS3_N = 1'b1;
      exp_req();
      for (int i = 1; i < TO; i++) begin
         junk(); IS3_N = 1'b1; exp_req();
      end
      junk(); IS3_N = 1'b1; exp_idle(1'b0, 1'b1);
      START = 1'b0; exp_idle(1'b0, 1'b0);
      chk("timeout_err_delay", err_cyc - os3_fall_cyc, TO);
      chk("timeout_no_strobe", st_ba.size(), 0);
      chk("timeout_err_count", err_cnt, 1);

      // 256-byte block wrapping through FFFF
      clear_mon();
      xfer(1'($urandom), 16'hFFFF, 8'd0, 0, -1, 1, -1);
      chk("wrap_strobe_count", st_ba.size(), 256);
      if (st_ba.size() == 256) begin
         chk("wrap_first_ba", int'(st_ba[0]), 32'hFFFF);
         chk("wrap_second_ba", int'(st_ba[1]), 32'h0000);
         chk("wrap_last_ba", int'(st_ba[255]), 32'h00FE);
      end
      chk("wrap_done_count", done_cnt, 1);

      // grant lost during second byte's strobe
      clear_mon();
      xfer(1'b1, 16'h3000, 8'd4, 0, 0, 0, 1);
      chk("loss_strobe_count", st_ba.size(), 2);
      chk("loss_err_count", err_cnt, 1);
      chk("loss_done_count", done_cnt, 0);

      // START held high while busy does not reload the count
      clear_mon();
      force_start = 1'b1;
      xfer(1'b0, 16'h4000, 8'd2, 1, 0, 0, -1);
      force_start = 1'b0;
      chk("start_busy_strobe_count", st_ba.size(), 2);

      // reset asserted mid-strobe
      START = 1'b1; WR = 1'b1; BASE_ADDR = 16'h2340; COUNT = 8'd5; IS3_N = 1'b1; WAIT_N = 1'b1;
      exp_req();
      junk(); IS3_N = 1'b0; exp_setup(16'h2340);
      junk(); IS3_N = 1'b0; exp_strobe(1'b1, 16'h2340);
      chk("strobe_before_reset", int'(N_BWR), 0);
      chk_en = 1'b0;
      #2 RESET = 1'b1;
      #1 chk("reset_outputs_async", int'({OS3_N, DMA_N, N_BWR, BRD_N, BUSY, DONE, ERR, BA}), 32'h0078_0000);
      @(negedge B_PHI);
      chk("reset_outputs_held", int'({OS3_N, DMA_N, N_BWR, BRD_N, BUSY, DONE, ERR, BA}), 32'h0078_0000);
      @(negedge B_PHI);
      RESET = 1'b0; START = 1'b0; IS3_N = 1'b1;
      chk_en = 1'b1;
      step(1'b1, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

      // randomized transfers
      for (int t = 0; t < 40; t++) begin
         int cnt;
         int ab;
         cnt = int'($urandom_range(1, 12));
         ab  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, cnt - 1)) : -1;
         xfer(1'($urandom), 16'($urandom), 8'(cnt), int'($urandom_range(0, 10)), -1, 3, ab);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
